pb_rgb_pwm_ctrl: RTL
====================

Name: pb_rgb_pwm_ctrl

Overview:
- Parametrised push-button to RGB LED controller for the Nexys 4 DDR board.
- Each of NUM_CH buttons is synchronised and debounced, then drives its own LED channel.
- A run-time mode selects how the button drives the channel: momentary, toggle, or brightness-step with PWM dimming.
- Sits between the board push-button pins and the tricolour LED pins; it supersedes direct button-to-LED wiring.

Parameters:
- NUM_CH, 3, number of button/LED channels (channel 0 = R, 1 = G, 2 = B by default).
- DB_CYCLES, 1000000, clocks an input must hold a new level before it is accepted (10 ms at 100 MHz); minimum 2.
- PWM_BITS, 8, width of the PWM counter and brightness level; MAX = 2^PWM_BITS-1.
- STEP, 64, brightness increment per press in step mode; 1 <= STEP <= MAX.

Ports:
- clk, input, 1, system clock (100 MHz on board).
- rst, input, 1, asynchronous active-high reset.
- pb, input, NUM_CH, raw push-button inputs, asynchronous, active-high.
- mode, input, 2, 0 = momentary, 1 = toggle, 2 = step/PWM, 3 = reserved (treated as momentary); synchronous to clk.
- led, output, NUM_CH, LED drive, active-high, registered.
- pb_db, output, NUM_CH, debounced button level.
- press, output, NUM_CH, one-cycle pulse on each debounced rising edge.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- Values on rst: led=0, pb_db=0, press=0, synchroniser flops=0, debounce counters=0, toggle bits=0, levels=0, PWM counter=0.
- Reset mid-operation clears all state immediately, with no clock edge required. After release the block behaves as from power-up; a button held through reset is seen as a new press after debounce.
- Synchroniser: two flops per channel, giving sync[i].
- Debounce, per channel:
  - When sync != pb_db, the counter increments each clock. When the counter is at DB_CYCLES-1 on a mismatch, pb_db flips and the counter clears.
  - Whenever sync == pb_db, the counter clears, so a glitch shorter than DB_CYCLES clocks is rejected.
  - Counter width is clog2(DB_CYCLES).
  - Latency: pb steady high → pb_db high exactly DB_CYCLES+2 clocks later.
- Press detect: press[i]=1 for exactly one clock, the cycle pb_db[i] goes 0→1. No pulse on release.
- Toggle bit: flips on press[i] only while mode==1; holds otherwise.
- Level register (PWM_BITS wide) updates on press[i] only while mode==2:
  - if level==MAX, next level=0 (wrap);
  - else if level+STEP>MAX, next level=MAX (saturate);
  - else next level=level+STEP.
  - Compute the sum one bit wider, with no overflow.
  - Default sequence: 0, 64, 128, 192, 255, 0, …
- PWM counter: single free-running counter shared by all channels, 0..MAX then wraps to 0.
- Duty per channel by mode: momentary → pb_db ? MAX : 0; toggle → toggle ? MAX : 0; step → level.
- LED output: led[i] registered = (duty==MAX) | (pwm_cnt < duty).
  - duty 0 → constantly off; duty MAX → constantly on; otherwise high for duty out of 2^PWM_BITS cycles.
  - One clock latency from duty to led.
- Mode change: takes effect on the next clock. Toggle and level values are retained across mode switches and are not reset.
- Simultaneous presses on several channels are handled independently in the same cycle.
- A press coincident with a mode change is applied under the mode sampled in that cycle.

Decomposition:
- Shared package pb_rgb_pkg:
  - mode encodings MODE_MOMENTARY=2'd0, MODE_TOGGLE=2'd1, MODE_STEP=2'd2;
  - default channel indices CH_R=0, CH_G=1, CH_B=2.
- Sub-module pb_debounce, one instance per channel: synchroniser, debounce counter and press pulse; parameter DB_CYCLES; ports clk, rst, pb_in, pb_db, press.
- The top level holds the toggle and level registers, the shared PWM counter and the output compare.

Test Plan (sim with DB_CYCLES=4, PWM_BITS=8, STEP=64):
- Reset check: assert rst asynchronously mid-cycle with buttons held → led, pb_db and press go to 0 immediately; after release, pb_db[0] reasserts 6 clocks later.
- Glitch rejection: mode=0; pulse pb[0] high for 3 clocks → pb_db and led stay 0; hold 10 clocks → pb_db[0] rises 6 clocks after pb, press[0] pulses once, led[0]=1 one clock later, then falls after release plus debounce.
- Toggle mode: mode=1; two separate presses on pb[1] → led[1] goes 1 after the first press and 0 after the second; exactly two press pulses; releases cause no change.
- Step wrap: mode=2; six presses on pb[2] → level 64, 128, 192, 255, 0, 64. At level 64, led[2] is high for exactly 64 of 256 cycles per PWM period; at 255 it is constantly high; at 0 it is constantly low.
- Channel and mode independence:
  - press pb[0] and pb[2] in the same cycle in mode 2 → both levels step in that cycle.
  - switch to mode 1 and back to mode 2 → levels are retained.
  - mode=3 behaves as momentary.

Source files
------------

// File: rtl/pb_rgb_pkg.sv
// Shared definitions for the push-button RGB PWM controller.
// Mode encodings and default channel indices.
`timescale 1ns/1ps
package pb_rgb_pkg;

    typedef enum logic [1:0] {
        MODE_MOMENTARY = 2'd0,
        MODE_TOGGLE    = 2'd1,
        MODE_STEP      = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

endpackage

// File: rtl/pb_debounce.sv
// Per-button two-flop synchroniser, debounce counter
// and rising-edge press pulse.
`timescale 1ns/1ps
module pb_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_db,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          expire;

    assign mismatch = sync_q[1] ^ pb_db;
    assign expire   = mismatch && (cnt == CNT_LAST);

    // Any return to agreement clears the count, so short glitches vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            pb_db  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pb_in};
            press  <= expire && !pb_db;
            if (expire) begin
                pb_db <= ~pb_db;
                cnt   <= '0;
            end else if (mismatch) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pb_rgb_pwm_ctrl.sv
// Push-button to RGB LED controller: momentary, toggle
// or brightness-step modes with a shared PWM counter.
`timescale 1ns/1ps
module pb_rgb_pwm_ctrl
    import pb_rgb_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DB_CYCLES = 1000000,
    parameter int PWM_BITS  = 8,
    parameter int STEP      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pb,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] pb_db,
    output logic [NUM_CH-1:0] press
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(STEP);

    mode_e               m;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_CH-1:0]   tog;
    logic [PWM_BITS-1:0] level [NUM_CH];
    logic [PWM_BITS-1:0] duty  [NUM_CH];
    logic [NUM_CH-1:0]   led_nxt;

    assign m = mode_e'(mode);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_db
        pb_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .pb_in(pb[g]),
            .pb_db(pb_db[g]),
            .press(press[g])
        );
    end

    // Full level wraps to zero; otherwise add STEP and saturate at MAX.
    function automatic logic [PWM_BITS-1:0] step_level(
        input logic [PWM_BITS-1:0] lv
    );
        logic [PWM_BITS:0] sum;
        sum = {1'b0, lv} + STEP_EXT;
        if (lv == MAX)
            return '0;
        else if (sum > {1'b0, MAX})
            return MAX;
        else
            return sum[PWM_BITS-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty[i] = '0;
            case (m)
                MODE_TOGGLE: duty[i] = tog[i] ? MAX : '0;
                MODE_STEP:   duty[i] = level[i];
                default:     duty[i] = pb_db[i] ? MAX : '0;
            endcase
            led_nxt[i] = (duty[i] == MAX) || (pwm_cnt < duty[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            tog     <= '0;
            led     <= '0;
            for (int i = 0; i < NUM_CH; i++)
                level[i] <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= led_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (press[i] && m == MODE_TOGGLE)
                    tog[i] <= ~tog[i];
                if (press[i] && m == MODE_STEP)
                    level[i] <= step_level(level[i]);
            end
        end
    end

endmodule
